riscv_pu_hazard_ctrl: RTL and testbench
=======================================

Name: riscv_pu_hazard_ctrl

Overview:
Pipeline hazard controller for the RISC-V pipeline. It generates the per-stage stall, flush and bubble controls consumed by the IF, ID and EX stage registers; its o_if_flush/o_if_stall drive the IF stage's flush/stall inputs. It detects load-use hazards, EX-resolved branch/jump redirects, data-memory wait states and multi-cycle MUL/DIV (MDU) occupancy, and arbitrates between them with a fixed priority.

Parameters:
REG_ADDR_W, 5, register-file address width
FLUSH_CYCLES, 2, cycles o_if_flush stays high after a redirect (>=1)
MDU_TIMEOUT, 64, max cycles in MDU_WAIT before timeout error (>=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
enable  in  1  pipeline enable
i_id_rs1  in  REG_ADDR_W  ID-stage rs1 address
i_id_rs1_used  in  1  ID instruction reads rs1
i_id_rs2  in  REG_ADDR_W  ID-stage rs2 address
i_id_rs2_used  in  1  ID instruction reads rs2
i_ex_rd  in  REG_ADDR_W  EX-stage destination register
i_ex_is_load  in  1  EX instruction is a load
i_ex_redirect  in  1  branch/jump taken, resolved in EX
i_ex_mdu_start  in  1  EX issues MUL/DIV to the MDU
i_mdu_done  in  1  MDU result valid
i_dmem_wait  in  1  data memory not ready
o_if_stall  out  1  hold IF register
o_id_stall  out  1  hold ID register
o_ex_stall  out  1  hold EX register
o_if_flush  out  1  flush IF register
o_id_flush  out  1  flush ID register
o_ex_bubble  out  1  insert NOP into EX
o_mdu_timeout  out  1  sticky MDU timeout error
o_state  out  2  current FSM state, for debug

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. On reset, state=IDLE, flush_cnt=0, mdu_cnt=0 and o_mdu_timeout=0. All other outputs are combinational from the registered state and the inputs, and are forced to 0 while reset=1.
- FSM states, encoded on o_state: IDLE=0, MDU_WAIT=1, FLUSH=2.
- enable=0: state and counters hold. o_if_stall=o_id_stall=o_ex_stall=1; all flush and bubble outputs are 0.
- Priority when several hazards occur in the same cycle in IDLE: redirect > dmem_wait > MDU start > load-use.
- Redirect:
  - i_ex_redirect=1 in IDLE or FLUSH drives o_if_flush=o_id_flush=1 in the same cycle, with no stalls.
  - If FLUSH_CYCLES>1: next state is FLUSH and flush_cnt=FLUSH_CYCLES-1. Otherwise the FSM stays in IDLE.
  - In FLUSH, o_if_flush=1 every cycle. flush_cnt decrements each cycle and the FSM returns to IDLE when it hits 0.
  - A new redirect in FLUSH reloads flush_cnt.
  - A redirect in MDU_WAIT is ignored (EX holds the MDU op); the bench asserts this never happens.
- dmem_wait: in any state, all three stall outputs are 1. There are no flushes except a redirect already in progress. FLUSH counting pauses.
- Load-use hazard:
  - Condition: IDLE, i_ex_is_load=1, i_ex_rd!=0, and (i_id_rs1_used and rs1==rd) or (i_id_rs2_used and rs2==rd).
  - Response: o_if_stall=o_id_stall=1 and o_ex_bubble=1 for exactly that cycle. No state change.
  - rd==0 never stalls.
- MDU:
  - i_ex_mdu_start=1 in IDLE with no redirect and no dmem_wait moves the FSM to MDU_WAIT next cycle, with mdu_cnt=0. The start cycle itself does not stall.
  - In MDU_WAIT: o_if_stall=o_id_stall=o_ex_stall=1 while i_mdu_done=0.
  - On a cycle with i_mdu_done=1, all stalls are 0 and next state is IDLE.
  - mdu_cnt increments each MDU_WAIT cycle (saturating). On reaching MDU_TIMEOUT-1 without done, o_mdu_timeout is set (sticky until reset) and the FSM returns to IDLE.
  - A done and the timeout in the same cycle count as done: no error.
- Invariant: stall and flush are never both asserted for the same stage in the same cycle; flush wins.
- Reset asserted mid-MDU_WAIT or mid-FLUSH returns to IDLE on the next edge, with outputs low during reset.

Decomposition:
- riscv_pkg gains:
  - typedef enum logic [1:0] hz_state_t {HZ_IDLE, HZ_MDU_WAIT, HZ_FLUSH}
  - a packed struct hz_ctrl_t bundling the stall/flush/bubble bits for stage consumption
- One natural sub-module: riscv_pu_load_use_det. It is a purely combinational comparator (rs1/rs2 vs rd, with used flags and x0 check) that is reused by the forwarding unit.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, rs2_used=1 -> exactly one cycle with if_stall=id_stall=ex_bubble=1. With ex_rd=0 -> no stall.
- Redirect with FLUSH_CYCLES=2: one-cycle i_ex_redirect -> o_if_flush high for 2 cycles, o_id_flush for 1, o_state 0→2→0.
- Redirect and load-use in the same cycle -> flushes only, o_ex_bubble=0, stalls=0.
- MDU: start at cycle 0, done at cycle 6 -> all stalls high for cycles 1-5, low at cycle 6, state IDLE at cycle 7, o_mdu_timeout=0.
- MDU timeout with MDU_TIMEOUT=8 and done never asserted -> o_mdu_timeout=1 after 7 MDU_WAIT cycles and stays 1; FSM returns to IDLE; cleared only by reset.
- dmem_wait held 3 cycles during FLUSH (cnt=1) -> all stalls=1 for 3 cycles, flush_cnt frozen, FLUSH exits one cycle after wait drops. Reset pulse mid-MDU_WAIT -> state 0, outputs 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared types for the RISC-V pipeline units.
//   hz_state_t : hazard controller FSM states (encoding is visible on o_state)
//   hz_ctrl_t  : per-stage stall/flush/bubble bundle produced by the hazard
//                controller and consumed by the IF/ID/EX stage registers
// ---------------------------------------------------------------------------
package riscv_pkg;

   typedef enum logic [1:0] {
      HZ_IDLE     = 2'd0,
      HZ_MDU_WAIT = 2'd1,
      HZ_FLUSH    = 2'd2
   } hz_state_t;

   // Bit order (MSB first): if_stall, id_stall, ex_stall, if_flush, id_flush, ex_bubble
   typedef struct packed {
      logic if_stall;
      logic id_stall;
      logic ex_stall;
      logic if_flush;
      logic id_flush;
      logic ex_bubble;
   } hz_ctrl_t;

   localparam hz_ctrl_t HZ_CTRL_NONE      = 6'b000000;
   localparam hz_ctrl_t HZ_CTRL_STALL_ALL = 6'b111000;
   localparam hz_ctrl_t HZ_CTRL_REDIRECT  = 6'b000110;
   localparam hz_ctrl_t HZ_CTRL_LOAD_USE  = 6'b110001;
   localparam hz_ctrl_t HZ_CTRL_IF_FLUSH  = 6'b000100;

endpackage

// File: rtl/riscv_pu_load_use_det.sv
// ---------------------------------------------------------------------------
// riscv_pu_load_use_det
// Purely combinational source/destination register comparator. Flags a match
// when a valid, non-x0 destination equals a source operand that is actually
// read. Shared by the hazard controller (rd_valid = EX is a load) and the
// forwarding unit (rd_valid = EX/MEM writes the register file).
// Ports:
//   rs1, rs1_used  : first source address and its read flag
//   rs2, rs2_used  : second source address and its read flag
//   rd, rd_valid   : destination address and its qualifying flag
//   hazard         : 1 when a qualifying match is found
// ---------------------------------------------------------------------------
module riscv_pu_load_use_det #(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] rs1,
   input  logic                  rs1_used,
   input  logic [REG_ADDR_W-1:0] rs2,
   input  logic                  rs2_used,
   input  logic [REG_ADDR_W-1:0] rd,
   input  logic                  rd_valid,
   output logic                  hazard
);

   logic rd_live;
   logic rs1_hit;
   logic rs2_hit;

   // x0 is hard-wired to zero, so a write to it never produces a dependency.
   assign rd_live = rd_valid && (rd != '0);
   assign rs1_hit = rs1_used && (rs1 == rd);
   assign rs2_hit = rs2_used && (rs2 == rd);
   assign hazard  = rd_live && (rs1_hit || rs2_hit);

endmodule

// File: rtl/riscv_pu_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// riscv_pu_hazard_ctrl
// Pipeline hazard controller. Generates the stall/flush/bubble controls for
// the IF, ID and EX stage registers from load-use hazards, EX-resolved
// redirects, data-memory wait states and MDU occupancy.
// Fixed priority in IDLE: redirect > dmem_wait > MDU start > load-use.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   enable                 : pipeline enable (0 = freeze everything)
//   i_id_rs1/_used, i_id_rs2/_used : ID-stage source operands
//   i_ex_rd, i_ex_is_load  : EX-stage destination and load flag
//   i_ex_redirect          : taken branch/jump resolved in EX
//   i_ex_mdu_start         : EX issues a MUL/DIV
//   i_mdu_done             : MDU result valid
//   i_dmem_wait            : data memory not ready
//   o_if/id/ex_stall       : hold the stage register
//   o_if/id_flush          : flush the stage register
//   o_ex_bubble            : insert a NOP into EX
//   o_mdu_timeout          : sticky MDU timeout error
//   o_state                : current FSM state (debug)
// ---------------------------------------------------------------------------
module riscv_pu_hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int REG_ADDR_W   = 5,
   parameter int FLUSH_CYCLES = 2,
   parameter int MDU_TIMEOUT  = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [REG_ADDR_W-1:0] i_id_rs1,
   input  logic                  i_id_rs1_used,
   input  logic [REG_ADDR_W-1:0] i_id_rs2,
   input  logic                  i_id_rs2_used,
   input  logic [REG_ADDR_W-1:0] i_ex_rd,
   input  logic                  i_ex_is_load,
   input  logic                  i_ex_redirect,
   input  logic                  i_ex_mdu_start,
   input  logic                  i_mdu_done,
   input  logic                  i_dmem_wait,
   output logic                  o_if_stall,
   output logic                  o_id_stall,
   output logic                  o_ex_stall,
   output logic                  o_if_flush,
   output logic                  o_id_flush,
   output logic                  o_ex_bubble,
   output logic                  o_mdu_timeout,
   output logic [1:0]            o_state
);

   localparam int FL_W  = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
   localparam int CNT_W = (MDU_TIMEOUT  > 2) ? $clog2(MDU_TIMEOUT)  : 1;

   hz_state_t        state;
   hz_state_t        state_next;
   logic [FL_W-1:0]  flush_cnt;
   logic [FL_W-1:0]  flush_cnt_next;
   logic [CNT_W-1:0] mdu_cnt;
   logic [CNT_W-1:0] mdu_cnt_next;
   logic             mdu_timeout;
   logic             timeout_set;
   logic             load_use;
   hz_ctrl_t         ctrl;

   riscv_pu_load_use_det #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_load_use_det (
      .rs1      (i_id_rs1),
      .rs1_used (i_id_rs1_used),
      .rs2      (i_id_rs2),
      .rs2_used (i_id_rs2_used),
      .rd       (i_ex_rd),
      .rd_valid (i_ex_is_load),
      .hazard   (load_use)
   );

   // State and counter registers. The timeout flag only ever sets here, so it
   // stays high until the next reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= HZ_IDLE;
         flush_cnt   <= '0;
         mdu_cnt     <= '0;
         mdu_timeout <= 1'b0;
      end else begin
         state     <= state_next;
         flush_cnt <= flush_cnt_next;
         mdu_cnt   <= mdu_cnt_next;
         if (timeout_set) begin
            mdu_timeout <= 1'b1;
         end
      end
   end

   // Next-state and stage controls. Everything defaults to "hold state, no
   // control asserted"; enable=0 freezes the pipeline by stalling every stage
   // while leaving state and counters untouched.
   always_comb begin
      state_next     = state;
      flush_cnt_next = flush_cnt;
      mdu_cnt_next   = mdu_cnt;
      timeout_set    = 1'b0;
      ctrl           = HZ_CTRL_NONE;

      if (reset) begin
         ctrl = HZ_CTRL_NONE;
      end else if (!enable) begin
         ctrl = HZ_CTRL_STALL_ALL;
      end else begin
         case (state)
            HZ_IDLE: begin
               if (i_ex_redirect) begin
                  ctrl = HZ_CTRL_REDIRECT;
                  if (FLUSH_CYCLES > 1) begin
                     state_next     = HZ_FLUSH;
                     flush_cnt_next = FL_W'(FLUSH_CYCLES - 1);
                  end
               end else if (i_dmem_wait) begin
                  ctrl = HZ_CTRL_STALL_ALL;
               end else if (i_ex_mdu_start) begin
                  state_next   = HZ_MDU_WAIT;
                  mdu_cnt_next = '0;
               end else if (load_use) begin
                  ctrl = HZ_CTRL_LOAD_USE;
               end
            end

            HZ_FLUSH: begin
               // A memory wait freezes the flush sequence: no flush is issued
               // and the counter holds so the remaining cycles resume after.
               if (i_ex_redirect) begin
                  ctrl           = HZ_CTRL_REDIRECT;
                  flush_cnt_next = FL_W'(FLUSH_CYCLES - 1);
               end else if (i_dmem_wait) begin
                  ctrl = HZ_CTRL_STALL_ALL;
               end else begin
                  ctrl           = HZ_CTRL_IF_FLUSH;
                  flush_cnt_next = flush_cnt - FL_W'(1);
                  if (flush_cnt <= FL_W'(1)) begin
                     state_next     = HZ_IDLE;
                     flush_cnt_next = '0;
                  end
               end
            end

            HZ_MDU_WAIT: begin
               // Redirects are ignored here because EX is still holding the
               // MDU instruction. Done beats a coincident timeout.
               if (i_mdu_done) begin
                  state_next = HZ_IDLE;
               end else begin
                  ctrl = HZ_CTRL_STALL_ALL;
                  if (mdu_cnt != '1) begin
                     mdu_cnt_next = mdu_cnt + CNT_W'(1);
                  end
                  if (mdu_cnt >= CNT_W'(MDU_TIMEOUT - 2)) begin
                     timeout_set = 1'b1;
                     state_next  = HZ_IDLE;
                  end
               end
               if (i_dmem_wait) begin
                  ctrl = HZ_CTRL_STALL_ALL;
               end
            end

            default: begin
               state_next = HZ_IDLE;
            end
         endcase
      end
   end

   assign o_if_stall    = ctrl.if_stall;
   assign o_id_stall    = ctrl.id_stall;
   assign o_ex_stall    = ctrl.ex_stall;
   assign o_if_flush    = ctrl.if_flush;
   assign o_id_flush    = ctrl.id_flush;
   assign o_ex_bubble   = ctrl.ex_bubble;
   assign o_mdu_timeout = mdu_timeout;
   assign o_state       = state;

endmodule

// File: tb/tb_riscv_pu_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_riscv_pu_hazard_ctrl
// Self-checking bench for the hazard controller (FLUSH_CYCLES=2,
// MDU_TIMEOUT=8). Single-cycle cases come from a vector table; multi-cycle
// cases (redirect flush, MDU wait/timeout, memory wait in FLUSH, mid-sequence
// reset) are hand-written sequences. Expected values travel through a
// scoreboard queue from the driving task to the checking task.
// ---------------------------------------------------------------------------
module tb_riscv_pu_hazard_ctrl;

   localparam int REG_ADDR_W   = 5;
   localparam int FLUSH_CYCLES = 2;
   localparam int MDU_TIMEOUT  = 8;

   // Control bundles, MSB first: if_stall id_stall ex_stall if_flush id_flush ex_bubble
   localparam logic [5:0] C_NONE  = 6'b000000;
   localparam logic [5:0] C_STALL = 6'b111000;
   localparam logic [5:0] C_LU    = 6'b110001;
   localparam logic [5:0] C_RDR   = 6'b000110;
   localparam logic [5:0] C_IFF   = 6'b000100;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  enable;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic                  id_rs1_used;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_rs2_used;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  ex_is_load;
   logic                  ex_redirect;
   logic                  ex_mdu_start;
   logic                  mdu_done;
   logic                  dmem_wait;
   logic                  if_stall;
   logic                  id_stall;
   logic                  ex_stall;
   logic                  if_flush;
   logic                  id_flush;
   logic                  ex_bubble;
   logic                  mdu_timeout;
   logic [1:0]            state;

   typedef struct packed {
      logic                  rst;
      logic                  en;
      logic [REG_ADDR_W-1:0] rs1;
      logic                  rs1_used;
      logic [REG_ADDR_W-1:0] rs2;
      logic                  rs2_used;
      logic [REG_ADDR_W-1:0] rd;
      logic                  is_load;
      logic                  redirect;
      logic                  mdu_start;
      logic                  mdu_done;
      logic                  dmem_wait;
   } stim_t;

   typedef struct packed {
      logic [5:0] ctrl;
      logic       timeout;
      logic [1:0] st;
   } exp_t;

   typedef struct {
      stim_t stim;
      exp_t  exp;
      exp_t  mask;
   } vec_t;

   localparam exp_t MASK_FULL  = 9'b111111_1_11;
   localparam exp_t MASK_RESET = 9'b111111_0_00;

   vec_t vec_table[$];
   vec_t sb_q[$];
   int   vectors_applied = 0;
   int   miscompares     = 0;

   always #5 clk = ~clk;

   riscv_pu_hazard_ctrl #(
      .REG_ADDR_W   (REG_ADDR_W),
      .FLUSH_CYCLES (FLUSH_CYCLES),
      .MDU_TIMEOUT  (MDU_TIMEOUT)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .i_id_rs1       (id_rs1),
      .i_id_rs1_used  (id_rs1_used),
      .i_id_rs2       (id_rs2),
      .i_id_rs2_used  (id_rs2_used),
      .i_ex_rd        (ex_rd),
      .i_ex_is_load   (ex_is_load),
      .i_ex_redirect  (ex_redirect),
      .i_ex_mdu_start (ex_mdu_start),
      .i_mdu_done     (mdu_done),
      .i_dmem_wait    (dmem_wait),
      .o_if_stall     (if_stall),
      .o_id_stall     (id_stall),
      .o_ex_stall     (ex_stall),
      .o_if_flush     (if_flush),
      .o_id_flush     (id_flush),
      .o_ex_bubble    (ex_bubble),
      .o_mdu_timeout  (mdu_timeout),
      .o_state        (state)
   );

   function automatic stim_t idle_s();
      stim_t s;
      s    = '0;
      s.en = 1'b1;
      return s;
   endfunction

   function automatic stim_t lu_s(input logic [4:0] rs1, input logic u1,
                                  input logic [4:0] rs2, input logic u2,
                                  input logic [4:0] rd, input logic ld);
      stim_t s;
      s          = idle_s();
      s.rs1      = rs1;
      s.rs1_used = u1;
      s.rs2      = rs2;
      s.rs2_used = u2;
      s.rd       = rd;
      s.is_load  = ld;
      return s;
   endfunction

   function automatic exp_t ex(input logic [5:0] c, input logic t, input logic [1:0] st);
      exp_t e;
      e.ctrl    = c;
      e.timeout = t;
      e.st      = st;
      return e;
   endfunction

   function automatic vec_t mk(input stim_t s, input exp_t e);
      vec_t v;
      v.stim = s;
      v.exp  = e;
      v.mask = MASK_FULL;
      return v;
   endfunction

   // Drive one cycle of stimulus just after the active edge and queue the
   // result it should produce.
   task automatic applyStimulus(input stim_t s, input exp_t e, input exp_t m);
      vec_t v;
      @(posedge clk);
      #1;
      reset        = s.rst;
      enable       = s.en;
      id_rs1       = s.rs1;
      id_rs1_used  = s.rs1_used;
      id_rs2       = s.rs2;
      id_rs2_used  = s.rs2_used;
      ex_rd        = s.rd;
      ex_is_load   = s.is_load;
      ex_redirect  = s.redirect;
      ex_mdu_start = s.mdu_start;
      mdu_done     = s.mdu_done;
      dmem_wait    = s.dmem_wait;
      v.stim = s;
      v.exp  = e;
      v.mask = m;
      sb_q.push_back(v);
   endtask

   // Sample on the falling edge and compare against the oldest queued result.
   task automatic checkOutput(input string tag);
      vec_t v;
      exp_t act;
      @(negedge clk);
      vectors_applied++;
      if (sb_q.size() == 0) begin
         miscompares++;
         $display("[TB] FAIL %s: scoreboard empty, nothing to compare", tag);
         return;
      end
      v           = sb_q.pop_front();
      act.ctrl    = {if_stall, id_stall, ex_stall, if_flush, id_flush, ex_bubble};
      act.timeout = mdu_timeout;
      act.st      = state;
      if ((9'(act) & 9'(v.mask)) !== (9'(v.exp) & 9'(v.mask))) begin
         miscompares++;
         $display("[TB] FAIL %s: got ctrl=%b timeout=%b state=%0d, expected ctrl=%b timeout=%b state=%0d (mask %b)",
                  tag, act.ctrl, act.timeout, act.st, v.exp.ctrl, v.exp.timeout, v.exp.st, 9'(v.mask));
      end
   endtask

   task automatic step(input stim_t s, input exp_t e, input string tag);
      applyStimulus(s, e, MASK_FULL);
      checkOutput(tag);
   endtask

   // During the reset cycle the registered state/timeout still show their old
   // values, so only the forced-low stage controls are compared.
   task automatic step_reset(input stim_t s, input string tag);
      stim_t r;
      r     = s;
      r.rst = 1'b1;
      applyStimulus(r, ex(C_NONE, 1'b0, 2'd0), MASK_RESET);
      checkOutput(tag);
   endtask

   // Per-stage exclusivity of stall and flush, plus the stimulus rule that no
   // redirect is presented while the MDU occupies EX.
   always @(negedge clk) begin
      if ((if_stall && if_flush) || (id_stall && id_flush)) begin
         miscompares++;
         $display("[TB] FAIL stall_flush_excl: if %b/%b id %b/%b, expected never both", if_stall, if_flush, id_stall, id_flush);
      end
      if (state == 2'd1 && ex_redirect === 1'b1) begin
         miscompares++;
         $display("[TB] FAIL redirect_in_mdu_wait: redirect=1 while state=%0d", state);
      end
   end

   initial begin
      stim_t s;

      reset        = 1'b1;
      enable       = 1'b0;
      id_rs1       = '0;
      id_rs1_used  = 1'b0;
      id_rs2       = '0;
      id_rs2_used  = 1'b0;
      ex_rd        = '0;
      ex_is_load   = 1'b0;
      ex_redirect  = 1'b0;
      ex_mdu_start = 1'b0;
      mdu_done     = 1'b0;
      dmem_wait    = 1'b0;

      // Single-cycle vectors; every row leaves the FSM in IDLE.
      vec_table.push_back(mk(idle_s(),                          ex(C_NONE,  0, 0)));
      vec_table.push_back(mk(lu_s(0, 0, 5, 1, 5, 1),            ex(C_LU,    0, 0)));
      vec_table.push_back(mk(lu_s(0, 1, 0, 1, 0, 1),            ex(C_NONE,  0, 0)));
      vec_table.push_back(mk(lu_s(7, 1, 3, 1, 7, 1),            ex(C_LU,    0, 0)));
      vec_table.push_back(mk(lu_s(7, 0, 3, 1, 7, 1),            ex(C_NONE,  0, 0)));
      vec_table.push_back(mk(lu_s(7, 1, 7, 1, 7, 0),            ex(C_NONE,  0, 0)));
      vec_table.push_back(mk(lu_s(2, 1, 9, 0, 9, 1),            ex(C_NONE,  0, 0)));
      vec_table.push_back(mk(lu_s(31, 1, 0, 0, 31, 1),          ex(C_LU,    0, 0)));
      s = lu_s(4, 1, 0, 0, 4, 1); s.en = 1'b0;
      vec_table.push_back(mk(s,                                 ex(C_STALL, 0, 0)));
      s = lu_s(4, 1, 0, 0, 4, 1); s.dmem_wait = 1'b1;
      vec_table.push_back(mk(s,                                 ex(C_STALL, 0, 0)));
      s = idle_s(); s.dmem_wait = 1'b1; s.mdu_start = 1'b1;
      vec_table.push_back(mk(s,                                 ex(C_STALL, 0, 0)));
      s = idle_s(); s.en = 1'b0; s.mdu_start = 1'b1;
      vec_table.push_back(mk(s,                                 ex(C_STALL, 0, 0)));
      vec_table.push_back(mk(idle_s(),                          ex(C_NONE,  0, 0)));

      step_reset(idle_s(), "reset_0");
      step(idle_s(), ex(C_NONE, 0, 0), "after_reset");

      for (int i = 0; i < vec_table.size(); i++) begin
         applyStimulus(vec_table[i].stim, vec_table[i].exp, vec_table[i].mask);
         checkOutput($sformatf("table_%0d", i));
      end

      // One-cycle redirect: two cycles of IF flush, one of ID flush.
      s = idle_s(); s.redirect = 1'b1;
      step(s,        ex(C_RDR,  0, 0), "redirect_c0");
      step(idle_s(), ex(C_IFF,  0, 2), "redirect_c1");
      step(idle_s(), ex(C_NONE, 0, 0), "redirect_c2");

      // Redirect beats a simultaneous load-use; load-use is ignored in FLUSH.
      s = lu_s(0, 0, 5, 1, 5, 1); s.redirect = 1'b1;
      step(s,                       ex(C_RDR,  0, 0), "rdr_lu_c0");
      step(lu_s(0, 0, 5, 1, 5, 1),  ex(C_IFF,  0, 2), "rdr_lu_c1");
      step(lu_s(0, 0, 5, 1, 5, 1),  ex(C_LU,   0, 0), "rdr_lu_c2");
      step(idle_s(),                ex(C_NONE, 0, 0), "rdr_lu_c3");

      // Redirect beats dmem_wait and MDU start, then a 3-cycle memory wait
      // freezes the flush sequence.
      s = idle_s(); s.redirect = 1'b1; s.dmem_wait = 1'b1; s.mdu_start = 1'b1;
      step(s, ex(C_RDR, 0, 0), "flush_dmem_c0");
      for (int i = 0; i < 3; i++) begin
         s = idle_s(); s.dmem_wait = 1'b1;
         step(s, ex(C_STALL, 0, 2), $sformatf("flush_dmem_wait%0d", i));
      end
      step(idle_s(), ex(C_IFF,  0, 2), "flush_dmem_resume");
      step(idle_s(), ex(C_NONE, 0, 0), "flush_dmem_exit");

      // MDU: start at cycle 0, done at cycle 6.
      s = idle_s(); s.mdu_start = 1'b1;
      step(s, ex(C_NONE, 0, 0), "mdu_start");
      for (int i = 1; i <= 5; i++) begin
         step(idle_s(), ex(C_STALL, 0, 1), $sformatf("mdu_wait%0d", i));
      end
      s = idle_s(); s.mdu_done = 1'b1;
      step(s,        ex(C_NONE, 0, 1), "mdu_done");
      step(idle_s(), ex(C_NONE, 0, 0), "mdu_back_idle");

      // enable=0 inside MDU_WAIT holds the state even with done present.
      s = idle_s(); s.mdu_start = 1'b1;
      step(s,        ex(C_NONE,  0, 0), "mdu_en_start");
      step(idle_s(), ex(C_STALL, 0, 1), "mdu_en_wait");
      s = idle_s(); s.en = 1'b0; s.mdu_done = 1'b1;
      step(s,        ex(C_STALL, 0, 1), "mdu_en_frozen");
      s = idle_s(); s.mdu_done = 1'b1;
      step(s,        ex(C_NONE,  0, 1), "mdu_en_done");
      step(idle_s(), ex(C_NONE,  0, 0), "mdu_en_idle");

      // Done arriving in the would-be timeout cycle counts as done.
      s = idle_s(); s.mdu_start = 1'b1;
      step(s, ex(C_NONE, 0, 0), "mdu_race_start");
      for (int i = 1; i <= 6; i++) begin
         step(idle_s(), ex(C_STALL, 0, 1), $sformatf("mdu_race_wait%0d", i));
      end
      s = idle_s(); s.mdu_done = 1'b1;
      step(s,        ex(C_NONE, 0, 1), "mdu_race_done");
      step(idle_s(), ex(C_NONE, 0, 0), "mdu_race_no_error");

      // Timeout: 7 MDU_WAIT cycles without done, sticky until reset.
      s = idle_s(); s.mdu_start = 1'b1;
      step(s, ex(C_NONE, 0, 0), "mdu_to_start");
      for (int i = 1; i <= 7; i++) begin
         step(idle_s(), ex(C_STALL, 0, 1), $sformatf("mdu_to_wait%0d", i));
      end
      step(idle_s(),               ex(C_NONE, 1, 0), "mdu_to_set");
      step(lu_s(6, 1, 0, 0, 6, 1), ex(C_LU,   1, 0), "mdu_to_sticky");
      step_reset(idle_s(), "mdu_to_reset");
      step(idle_s(), ex(C_NONE, 0, 0), "mdu_to_cleared");

      // Reset mid-MDU_WAIT, with enable low and dmem_wait high.
      s = idle_s(); s.mdu_start = 1'b1;
      step(s,        ex(C_NONE,  0, 0), "rst_mdu_start");
      step(idle_s(), ex(C_STALL, 0, 1), "rst_mdu_wait1");
      step(idle_s(), ex(C_STALL, 0, 1), "rst_mdu_wait2");
      s = idle_s(); s.en = 1'b0; s.dmem_wait = 1'b1;
      step_reset(s, "rst_mdu_pulse");
      step(idle_s(), ex(C_NONE, 0, 0), "rst_mdu_idle");

      // Reset mid-FLUSH.
      s = idle_s(); s.redirect = 1'b1;
      step(s, ex(C_RDR, 0, 0), "rst_flush_rdr");
      s = idle_s(); s.dmem_wait = 1'b1;
      step_reset(s, "rst_flush_pulse");
      step(idle_s(), ex(C_NONE, 0, 0), "rst_flush_idle");

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
